// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared FSM state encoding and counter sizing for enable_pulse_gen
//   IDLE/HELD/REPEAT/RUN : 2-bit state codes, also exported on state_o
//   cnt_width()          : bits needed to hold 0..terminal-1 (never below 1)
package ctrl_pkg;
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HELD   = 2'd1;
    localparam logic [1:0] REPEAT = 2'd2;
    localparam logic [1:0] RUN    = 2'd3;

    function automatic int cnt_width(input int terminal);
        return (terminal > 1) ? $clog2(terminal) : 1;
    endfunction
endpackage

// File: rtl/enable_pulse_gen_sync_debounce.sv
// sync_debounce: synchronizer chain plus debounce filter for a raw push-button
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   din          : raw asynchronous button
//   level        : debounced level (registered)
//   level_nxt    : value level takes at the next edge, so the caller can act on
//                  an accepted change in the same cycle the level register flips
module sync_debounce
    import ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic level_nxt
);
    localparam int CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Plain shift chain; each stage must stay a distinct flop for metastability settling.
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   btn_sync, differs, done;

    assign btn_sync  = sync_q[SYNC_STAGES-1];
    assign differs   = btn_sync != level_q;
    assign done      = cnt_q == CNT_LAST;
    assign level     = level_q;
    assign level_nxt = level_d;

    // Any sample agreeing with the current level restarts the count, so only an
    // uninterrupted run of DEBOUNCE_CYCLES differing samples flips the level.
    always_comb begin
        cnt_d   = (differs && !done) ? cnt_q + CW'(1) : '0;
        level_d = (differs && done) ? btn_sync : level_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], din};
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end
endmodule

// File: rtl/enable_pulse_gen.sv
// enable_pulse_gen: push-button to single-cycle counter-enable pulses
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   btn_in       : raw bouncy button, asynchronous to clock
//   auto_repeat  : held button produces repeat pulses
//   run          : free-run pulse every TICK_DIV cycles, button ignored
//   enable       : registered single-cycle pulse to the counter
//   btn_level    : debounced button level
//   state_o      : FSM state (IDLE/HELD/REPEAT/RUN) for debug
module enable_pulse_gen
    import ctrl_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 32,
    parameter int TICK_DIV        = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_in,
    input  logic       auto_repeat,
    input  logic       run,
    output logic       enable,
    output logic       btn_level,
    output logic [1:0] state_o
);
    localparam int HW = cnt_width(HOLD_CYCLES);
    localparam int TW = cnt_width(TICK_DIV);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] tick_q, tick_d;
    logic          en_q, en_d;
    logic          lvl_nxt, rise, tick_wrap;

    sync_debounce #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock    (clock),
        .reset    (reset),
        .din      (btn_in),
        .level    (btn_level),
        .level_nxt(lvl_nxt)
    );

    // Decisions use the level being latched this edge, so the press pulse lines
    // up with btn_level rising and a release beats a coincident repeat tick.
    assign rise      = lvl_nxt & ~btn_level;
    assign tick_wrap = tick_q == TICK_LAST;
    assign enable    = en_q;
    assign state_o   = state_q;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        tick_d  = tick_q;
        en_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (run) begin
                    state_d = RUN;
                    tick_d  = '0;
                end else if (rise) begin
                    state_d = HELD;
                    hold_d  = '0;
                    en_d    = 1'b1;
                end
            end
            HELD: begin
                if (run) begin
                    state_d = RUN;
                    tick_d  = '0;
                end else if (!lvl_nxt) begin
                    state_d = IDLE;
                end else if (auto_repeat) begin
                    state_d = (hold_q == HOLD_LAST) ? REPEAT : HELD;
                    en_d    = hold_q == HOLD_LAST;
                    tick_d  = '0;
                    hold_d  = (hold_q == HOLD_LAST) ? hold_q : hold_q + HW'(1);
                end
            end
            REPEAT: begin
                if (run) begin
                    state_d = RUN;
                    tick_d  = '0;
                end else if (!lvl_nxt) begin
                    state_d = IDLE;
                end else if (!auto_repeat) begin
                    state_d = HELD;
                    hold_d  = '0;
                end else begin
                    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                    en_d   = tick_wrap;
                end
            end
            default: begin
                if (!run) begin
                    state_d = IDLE;
                end else begin
                    tick_d = tick_wrap ? '0 : tick_q + TW'(1);
                    en_d   = tick_wrap;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= '0;
            tick_q  <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            tick_q  <= tick_d;
            en_q    <= en_d;
        end
    end
endmodule

// File: tb/tb_enable_pulse_gen.sv
// tb_enable_pulse_gen: scoreboard bench for enable_pulse_gen against a behavioural model
module tb_enable_pulse_gen;
    localparam int S = 2;
    localparam int D = 4;
    localparam int H = 6;
    localparam int T = 3;

    logic       clock = 0, reset = 1, btn_in = 0, auto_repeat = 0, run = 0;
    logic       enable, btn_level;
    logic [1:0] state_o;

    enable_pulse_gen #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .TICK_DIV(T)
    ) dut (
        .clock(clock), .reset(reset), .btn_in(btn_in), .auto_repeat(auto_repeat),
        .run(run), .enable(enable), .btn_level(btn_level), .state_o(state_o)
    );

    always #5 clock = ~clock;

    typedef struct { int tag; logic [3:0] v; } exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0, cyc = 0, npul = 0, p0 = 0;
    logic [2:0] ctr = 0;
    logic tgt = 0, r_run = 0, r_ar = 0;

    // model state: mode 0..3 mirrors the published state codes
    int   m, held, rep_start, run_start, t, mcnt;
    logic lvl;
    logic pipe[$];
    logic recent[$];

    always @(posedge clock) cyc <= cyc + 1;

    // downstream 3-bit counter and raw pulse tally, sampled mid-cycle
    always @(negedge clock) begin
        if (enable) npul <= npul + 1;
        if (reset) ctr <= 3'd0;
        else if (enable) ctr <= ctr + 3'd1;
    end

    // monitor: compares every cycle for which an expectation was issued
    always @(negedge clock) begin
        while (sb.size() > 0 && sb[0].tag < cyc) begin
            total++; bad++;
            $display("FAIL missed_sample tag=%0d now=%0d", sb[0].tag, cyc);
            sb.delete(0);
        end
        if (sb.size() > 0 && sb[0].tag == cyc) begin
            e = sb.pop_front();
            total++;
            if ({enable, btn_level, state_o} !== e.v) begin
                bad++;
                $display("FAIL outputs cycle=%0d got en=%b lvl=%b st=%0d want en=%b lvl=%b st=%0d",
                         cyc, enable, btn_level, state_o, e.v[3], e.v[2], e.v[1:0]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        m = 0; held = 0; rep_start = 0; run_start = 0; t = 0; mcnt = 0; lvl = 0;
        pipe.delete();
        recent.delete();
        for (int i = 0; i < S; i++) pipe.push_back(1'b0);
    endtask

    // One clock edge of the reference: sync is a pure S-sample delay; the level
    // flips once the last D synced samples all disagree with it.
    task automatic model_step(input logic b, input logic a, input logic r, output logic [3:0] v);
        logic s, nl, rs, pulse;
        bit flip;
        t++;
        pipe.push_back(b);
        s = pipe.pop_front();
        recent.push_back(s);
        if (recent.size() > D) recent.delete(0);
        flip = recent.size() == D;
        foreach (recent[i]) if (recent[i] == lvl) flip = 0;
        nl = flip ? ~lvl : lvl;
        rs = nl && !lvl;
        lvl = nl;
        pulse = 0;
        if (m == 0) begin
            if (r) begin m = 3; run_start = t; end
            else if (rs) begin pulse = 1; m = 1; held = 0; end
        end else if (m == 1) begin
            if (r) begin m = 3; run_start = t; end
            else if (!nl) m = 0;
            else if (a) begin
                held++;
                if (held == H) begin pulse = 1; m = 2; rep_start = t; end
            end
        end else if (m == 2) begin
            if (r) begin m = 3; run_start = t; end
            else if (!nl) m = 0;
            else if (!a) begin m = 1; held = 0; end
            else if ((t - rep_start) % T == 0) pulse = 1;
        end else begin
            if (!r) m = 0;
            else if ((t - run_start) % T == 0) pulse = 1;
        end
        mcnt += int'(pulse);
        v = {pulse, lvl, 2'(m)};
    endtask

    task automatic step(input logic b, input logic a, input logic r);
        logic [3:0] v;
        btn_in = b; auto_repeat = a; run = r;
        model_step(b, a, r, v);
        sb.push_back('{tag: cyc + 1, v: v});
        @(posedge clock); #1;
    endtask

    task automatic settle();
        @(negedge clock); #1;
    endtask

    task automatic do_reset(input logic b);
        @(negedge clock); #2;
        reset = 1; btn_in = b;
        #1;
        chk("async_reset_outputs", int'({enable, btn_level, state_o}), 0);
        repeat (3) @(posedge clock);
        @(negedge clock); #2;
        reset = 0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1);
    end

    initial begin
        int want_rel[3] = '{4, 4, 5};
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock); #2;
        reset = 0;

        settle(); p0 = npul;
        repeat (10) step(1, 0, 0);
        settle(); chk("clean_press_pulses", npul - p0, 1);
        p0 = npul;
        repeat (10) step(0, 0, 0);
        settle(); chk("clean_release_pulses", npul - p0, 0);

        p0 = npul;
        step(1, 0, 0); step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);
        repeat (10) step(1, 0, 0);
        settle(); chk("bounce_pulses", npul - p0, 1);
        repeat (10) step(0, 0, 0);
        settle(); p0 = npul;
        repeat (3) step(1, 0, 0);
        repeat (10) step(0, 0, 0);
        settle(); chk("glitch_pulses", npul - p0, 0);

        p0 = npul;
        repeat (31) step(1, 1, 0);
        settle(); chk("auto_repeat_pulses", npul - p0, 8);
        chk("counter_mod8", int'(ctr), mcnt % 8);
        repeat (12) step(0, 1, 0);

        settle(); p0 = npul;
        repeat (10) step(0, 0, 1);
        settle(); chk("run_pulses", npul - p0, 3);
        p0 = npul;
        repeat (12) step(1, 0, 1);
        settle(); chk("run_press_ignored", npul - p0, 4);
        p0 = npul;
        repeat (8) step(1, 0, 0);
        settle(); chk("run_exit_held_no_pulse", npul - p0, 0);
        repeat (10) step(0, 0, 0);

        settle(); p0 = npul;
        repeat (5) step(1, 0, 0);
        step(1, 0, 1);
        settle(); chk("run_beats_press", npul - p0, 0);
        repeat (4) step(1, 0, 0);
        repeat (10) step(0, 0, 0);

        for (int k = 0; k < 3; k++) begin
            settle(); p0 = npul;
            repeat (14 + k) step(1, 1, 0);
            repeat (11 - k) step(0, 1, 0);
            settle(); chk($sformatf("release_vs_repeat_k%0d", k), npul - p0, want_rel[k]);
            repeat (6) step(0, 0, 0);
        end

        repeat (15) step(1, 1, 0);
        do_reset(1'b1);
        p0 = npul;
        repeat (11) step(1, 1, 0);
        settle(); chk("post_reset_pulses", npul - p0, 1);
        chk("post_reset_counter", int'(ctr), mcnt % 8);
        repeat (10) step(0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(24) == 0) tgt = ~tgt;
            if ($urandom_range(59) == 0) r_run = ~r_run;
            if ($urandom_range(39) == 0) r_ar = ~r_ar;
            if (i == 1500) do_reset(tgt);
            step(($urandom_range(7) == 0) ? ~tgt : tgt, r_ar, r_run);
        end

        settle();
        chk("final_counter", int'(ctr), mcnt % 8);
        chk("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
